// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a bouncy asynchronous input and accepts a new level only
// after STABLE_CYCLES consecutive identical samples; emits one-cycle rise/fall strobes.
`default_nettype none

module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // An opposite sample during a WAIT_* state silently abandons the attempt.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (sync_in) begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync_in) begin
          state_d = LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (!sync_in) begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LOW: begin
        if (sync_in) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = LOW;
      end
    endcase
  end

  // clean is registered from the next state so it has no path from raw_in.
  assign clean_d = (state_d == HIGH) || (state_d == WAIT_LOW);

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of the debouncer with default and swept parameters.
`default_nettype none

module tb_input_debouncer;

  logic clk = 1'b0;
  logic reset;
  logic raw_in, raw2;
  logic clean, rise, fall;
  logic clean2, rise2, fall2;

  int tests = 0;
  int fails = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int r0, f0;
  logic [1:0] st;
  logic [1:0] cn;

  always #5 clk = ~clk;

  input_debouncer dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .clean(clean), .rise(rise), .fall(fall)
  );

  input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(8)) dut2 (
    .clk(clk), .reset(reset), .raw_in(raw2),
    .clean(clean2), .rise(rise2), .fall(fall2)
  );

  always @(negedge clk) begin
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new level and check clean/strobes around the 6-edge latency.
  task automatic level_change(input logic v);
    raw_in = v;
    tick(5);
    check("pre_latency_clean", int'(clean), int'(!v));
    tick(1);
    check("post_latency_clean", int'(clean), int'(v));
    check("edge_rise", int'(rise), int'(v));
    check("edge_fall", int'(fall), int'(!v));
    tick(1);
    check("strobe_clear", int'(rise | fall), 0);
    tick(3);
  endtask

  initial begin
    // Reset with raw_in high
    reset  = 1'b1;
    raw_in = 1'b1;
    raw2   = 1'b0;
    #2;
    check("reset_async_clean", int'(clean), 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_hold_outputs", int'({clean, rise, fall}), 0);
    end
    r0 = rise_cnt; f0 = fall_cnt;
    reset = 1'b0;
    tick(5);
    check("rel_pre_clean", int'(clean), 0);
    tick(1);
    check("rel_clean", int'(clean), 1);
    check("rel_rise", int'(rise), 1);
    tick(1);
    check("rel_rise_1cyc", int'(rise), 0);
    check("rel_rise_count", rise_cnt - r0, 1);
    check("rel_fall_count", fall_cnt - f0, 0);
    tick(3);

    // Clean step: 1->0 then 0->1 then back to 0
    r0 = rise_cnt; f0 = fall_cnt;
    level_change(1'b0);
    level_change(1'b1);
    check("step_rise_count", rise_cnt - r0, 1);
    check("step_fall_count", fall_cnt - f0, 1);
    level_change(1'b0);

    // Bounce 1,0,1,1,0,1 then hold 1
    r0 = rise_cnt;
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int i = 5; i >= 0; i--) begin
        raw_in = pat[i];
        tick(1);
        check("bounce_clean_low", int'(clean), 0);
      end
    end
    raw_in = 1'b1;
    tick(4);
    check("bounce_pre_accept", int'(clean), 0);
    tick(1);
    check("bounce_clean", int'(clean), 1);
    check("bounce_rise", int'(rise), 1);
    tick(3);
    check("bounce_rise_count", rise_cnt - r0, 1);

    // Glitch: 3-cycle low while clean is high
    f0 = fall_cnt;
    raw_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) raw_in = 1'b1;
      tick(1);
      check("glitch_clean_high", int'(clean), 1);
    end
    check("glitch_no_fall", fall_cnt - f0, 0);
    st = dut.state_q;
    check("glitch_state_high", int'(st), 2);

    // Reset mid-debounce in WAIT_HIGH with cnt=2
    level_change(1'b0);
    r0 = rise_cnt;
    raw_in = 1'b1;
    tick(4);
    st = dut.state_q;
    cn = dut.cnt_q;
    check("mid_state_wait_high", int'(st), 1);
    check("mid_cnt_two", int'(cn), 2);
    #2 reset = 1'b1;
    #1;
    cn = dut.cnt_q;
    st = dut.state_q;
    check("mid_reset_cnt", int'(cn), 0);
    check("mid_reset_state", int'(st), 0);
    check("mid_reset_clean", int'(clean), 0);
    raw_in = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(8);
    check("mid_no_rise", rise_cnt - r0, 0);
    check("mid_clean_low", int'(clean), 0);

    // Swept parameters: SYNC_STAGES=3, STABLE_CYCLES=8 -> change after E10
    raw2 = 1'b1;
    tick(10);
    check("p8_pre_clean", int'(clean2), 0);
    tick(1);
    check("p8_clean", int'(clean2), 1);
    check("p8_rise", int'(rise2), 1);
    tick(1);
    check("p8_rise_clear", int'(rise2), 0);
    tick(4);
    raw2 = 1'b0;
    tick(10);
    check("p8_pre_fall", int'(clean2), 1);
    tick(1);
    check("p8_clean_low", int'(clean2), 0);
    check("p8_fall", int'(fall2), 1);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
